// File: rtl/data_sram_resp_pkg.sv
// Shared types and widths for the data-side SRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package data_sram_resp_pkg;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_STRB_W = 4;

  // Countdown and occupancy widths cover the legal LATENCY/DEPTH range of 1..8.
  localparam int CD_W  = 3;
  localparam int CNT_W = 4;

  // One queued response: write flag plus the word captured at accept.
  typedef struct packed {
    logic                   wr;
    logic [SRAM_DATA_W-1:0] word;
  } resp_t;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [SRAM_DATA_W-1:0] byte_merge(
    input logic [SRAM_DATA_W-1:0] old_word,
    input logic [SRAM_DATA_W-1:0] new_word,
    input logic [SRAM_STRB_W-1:0] strb
  );
    logic [SRAM_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < SRAM_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_resp_fifo.sv
// In-order response queue; each entry counts down from LATENCY-1 to 0 before it may leave.
// Latency: an entry pushed in cycle C is head_ready in cycle C+LATENCY when it is at the head.
// Backpressure: none internally; the caller must not push when full unless it pops the same cycle.
module resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  resp_t            push_dat,
  input  logic             pop,
  output logic             head_ready,
  output resp_t            head_dat,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_t            ent    [DEPTH];
  logic [CD_W-1:0]  cd     [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Head is ready once its countdown has drained; only meaningful when non-empty.
  always_comb begin
    head_ready = (count != '0) && (cd[rd_ptr] == '0);
    head_dat   = ent[rd_ptr];
  end

  // Pointer and occupancy update; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload store; contents need no reset because occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push) ent[wr_ptr] <= push_dat;
  end

  // Every countdown loads on push and otherwise decrements, saturating at zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!resetn) begin
        cd[i] <= '0;
      end else if (push && (wr_ptr == PTR_W'(i))) begin
        cd[i] <= CD_W'(LATENCY - 1);
      end else if (cd[i] != '0) begin
        cd[i] <= cd[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: byte-masked word array with in-order, fixed-latency responses.
// Latency: data_ok exactly LATENCY cycles after the request handshake, for reads and writes.
// Backpressure: addr_ok refuses requests when stalled or when DEPTH responses are outstanding; data_ok cannot be held off.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req,
  input  logic                   wr,
  input  logic [31:0]            addr,
  input  logic [SRAM_STRB_W-1:0] wstrb,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic                   stall,
  output logic                   addr_ok,
  output logic                   data_ok,
  output logic [SRAM_DATA_W-1:0] rdata
);

  logic [SRAM_DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] word_idx;
  logic              retire;
  logic              head_ready;
  resp_t             head_dat;
  resp_t             push_dat;
  logic [CNT_W-1:0]  count;

  // Byte address to word index; higher bits alias.
  assign word_idx = addr[ADDR_W+1:2];

  // Accept rule: a full queue can still take a request in the cycle its head retires.
  always_comb begin
    retire  = head_ready;
    addr_ok = req && !stall && ((count < CNT_W'(DEPTH)) || retire);
  end

  // Reads capture the pre-write word at accept; write responses carry no data.
  always_comb begin
    push_dat.wr   = wr;
    push_dat.word = wr ? '0 : mem[word_idx];
  end

  // Byte-lane write at accept; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (addr_ok && wr) mem[word_idx] <= byte_merge(mem[word_idx], wdata, wstrb);
  end

  resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (addr_ok),
    .push_dat   (push_dat),
    .pop        (retire),
    .head_ready (head_ready),
    .head_dat   (head_dat),
    .count      (count)
  );

  // Response outputs; rdata is forced to zero except on a read response.
  always_comb begin
    data_ok = head_ready;
    rdata   = (head_ready && !head_dat.wr) ? head_dat.word : '0;
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp with two instances: default (LAT=2, DEPTH=4) and (LAT=4, DEPTH=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_data_sram_resp;

  logic clk = 1'b0;
  logic resetn;

  logic        a_req, a_wr, a_stall, a_addr_ok, a_data_ok;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_wstrb;

  logic        b_req, b_wr, b_stall, b_addr_ok, b_data_ok;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_wstrb;

  logic        s_ao, s_do;
  logic [31:0] s_rd;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .LATENCY(2), .DEPTH(4)) dut_a (
    .clk(clk), .resetn(resetn), .req(a_req), .wr(a_wr), .addr(a_addr),
    .wstrb(a_wstrb), .wdata(a_wdata), .stall(a_stall),
    .addr_ok(a_addr_ok), .data_ok(a_data_ok), .rdata(a_rdata)
  );

  data_sram_resp #(.ADDR_W(10), .LATENCY(4), .DEPTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .req(b_req), .wr(b_wr), .addr(b_addr),
    .wstrb(b_wstrb), .wdata(b_wdata), .stall(b_stall),
    .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive the selected instance (other idle), sample at the falling edge.
  task automatic cyc(input bit sel_b, input logic rq, input logic w, input logic [31:0] ad,
                     input logic [3:0] st, input logic [31:0] wd, input logic sl);
    a_req = 0; a_wr = 0; a_addr = 0; a_wstrb = 0; a_wdata = 0; a_stall = 0;
    b_req = 0; b_wr = 0; b_addr = 0; b_wstrb = 0; b_wdata = 0; b_stall = 0;
    if (sel_b) begin
      b_req = rq; b_wr = w; b_addr = ad; b_wstrb = st; b_wdata = wd; b_stall = sl;
    end else begin
      a_req = rq; a_wr = w; a_addr = ad; a_wstrb = st; a_wdata = wd; a_stall = sl;
    end
    @(negedge clk);
    s_ao = sel_b ? b_addr_ok : a_addr_ok;
    s_do = sel_b ? b_data_ok : a_data_ok;
    s_rd = sel_b ? b_rdata   : a_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit sel_b);
    cyc(sel_b, 0, 0, 32'h0, 4'h0, 32'h0, 0);
  endtask

  // Back-pressure expectations for the LAT=4 / DEPTH=2 instance, cycles 0..9.
  logic       bp_ao [6]  = '{1, 1, 0, 0, 1, 1};
  logic       bp_do [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
  logic [1:0] bp_ix [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 2, 3};

  initial begin
    int idx;
    resetn = 1'b0;
    a_req = 0; a_wr = 0; a_addr = 0; a_wstrb = 0; a_wdata = 0; a_stall = 0;
    b_req = 0; b_wr = 0; b_addr = 0; b_wstrb = 0; b_wdata = 0; b_stall = 0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state
    idle(0);
    chk("rst_a_addr_ok", 32'(s_ao), 32'd0);
    chk("rst_a_data_ok", 32'(s_do), 32'd0);
    chk("rst_a_rdata",   s_rd,      32'h0);
    idle(1);
    chk("rst_b_data_ok", 32'(s_do), 32'd0);

    // Read after write, LAT=2
    cyc(0, 1, 1, 32'h10, 4'hF, 32'hA1B2C3D4, 0);
    chk("raw_c0_addr_ok", 32'(s_ao), 32'd1);
    chk("raw_c0_data_ok", 32'(s_do), 32'd0);
    cyc(0, 1, 0, 32'h10, 4'h0, 32'h0, 0);
    chk("raw_c1_addr_ok", 32'(s_ao), 32'd1);
    chk("raw_c1_data_ok", 32'(s_do), 32'd0);
    idle(0);
    chk("raw_c2_data_ok", 32'(s_do), 32'd1);
    chk("raw_c2_rdata",   s_rd,      32'h0);
    idle(0);
    chk("raw_c3_data_ok", 32'(s_do), 32'd1);
    chk("raw_c3_rdata",   s_rd,      32'hA1B2C3D4);
    idle(0);
    chk("raw_c4_data_ok", 32'(s_do), 32'd0);
    chk("raw_c4_rdata",   s_rd,      32'h0);

    // Byte masking
    cyc(0, 1, 1, 32'h20, 4'hF, 32'h11223344, 0);
    cyc(0, 1, 1, 32'h20, 4'h6, 32'hFFFFFFFF, 0);
    cyc(0, 1, 0, 32'h20, 4'h0, 32'h0, 0);
    chk("mask_w1_rdata", s_rd, 32'h0);
    idle(0);
    chk("mask_w2_data_ok", 32'(s_do), 32'd1);
    idle(0);
    chk("mask_rd_data_ok", 32'(s_do), 32'd1);
    chk("mask_rd_rdata",   s_rd,      32'h11FFFF44);

    // Stall: three refused cycles, accepted on the fourth
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 32'h10, 4'h0, 32'h0, 1);
      chk($sformatf("stall_c%0d_addr_ok", i), 32'(s_ao), 32'd0);
    end
    cyc(0, 1, 0, 32'h10, 4'h0, 32'h0, 0);
    chk("stall_c3_addr_ok", 32'(s_ao), 32'd1);
    chk("stall_c3_data_ok", 32'(s_do), 32'd0);
    idle(0);
    chk("stall_c4_data_ok", 32'(s_do), 32'd0);
    idle(0);
    chk("stall_c5_data_ok", 32'(s_do), 32'd1);
    chk("stall_c5_rdata",   s_rd,      32'hA1B2C3D4);
    idle(0);
    chk("stall_c6_data_ok", 32'(s_do), 32'd0);

    // Aliasing: 0x1004 and 0x0004 hit the same word with ADDR_W=10
    cyc(0, 1, 1, 32'h00001004, 4'hF, 32'hCAFEF00D, 0);
    cyc(0, 1, 0, 32'h00000004, 4'h0, 32'h0, 0);
    idle(0);
    idle(0);
    chk("alias_data_ok", 32'(s_do), 32'd1);
    chk("alias_rdata",   s_rd,      32'hCAFEF00D);

    // Preload words for the LAT=4 / DEPTH=2 instance
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 1, 32'h40 + 32'(4 * k), 4'hF, 32'hB0000000 + 32'(k), 0);
      repeat (4) idle(1);
    end

    // Back-pressure: req held high until four reads are accepted
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) cyc(1, 1, 0, 32'h40 + 32'(4 * idx), 4'h0, 32'h0, 0);
      else       idle(1);
      if (c < 6) begin
        chk($sformatf("bp_c%0d_addr_ok", c), 32'(s_ao), 32'(bp_ao[c]));
        if (bp_ao[c]) idx++;
      end
      chk($sformatf("bp_c%0d_data_ok", c), 32'(s_do), 32'(bp_do[c]));
      if (bp_do[c])
        chk($sformatf("bp_c%0d_rdata", c), s_rd, 32'hB0000000 + 32'(bp_ix[c]));
    end

    // Reset mid-flight on the LAT=4 instance
    cyc(1, 1, 1, 32'h30, 4'hF, 32'h5A5A1234, 0);
    repeat (4) idle(1);
    chk("rmf_wr_data_ok", 32'(s_do), 32'd1);
    cyc(1, 1, 0, 32'h40, 4'h0, 32'h0, 0);
    chk("rmf_rd0_addr_ok", 32'(s_ao), 32'd1);
    cyc(1, 1, 0, 32'h44, 4'h0, 32'h0, 0);
    chk("rmf_rd1_addr_ok", 32'(s_ao), 32'd1);
    resetn = 1'b0;
    idle(1);
    chk("rmf_rst_data_ok", 32'(s_do), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk($sformatf("rmf_post%0d_data_ok", i), 32'(s_do), 32'd0);
      chk($sformatf("rmf_post%0d_rdata", i), s_rd, 32'h0);
    end
    cyc(1, 1, 0, 32'h30, 4'h0, 32'h0, 0);
    chk("rmf_persist_addr_ok", 32'(s_ao), 32'd1);
    repeat (3) begin
      idle(1);
      chk("rmf_persist_wait", 32'(s_do), 32'd0);
    end
    idle(1);
    chk("rmf_persist_data_ok", 32'(s_do), 32'd1);
    chk("rmf_persist_rdata",   s_rd,      32'h5A5A1234);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
